// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
// Shared definitions for the multi-cycle multiply/divide unit: operation
// encodings, FSM state encodings, the iteration count and small helpers
// that classify an operation.
package mul_div_unit_pkg;

  // Number of shift iterations for a 32-bit operand, and the counter width
  // needed to count them.
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  function automatic logic is_signed_op(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix
// Combinational conditional two's-complement negate. Used both to take the
// absolute value of an operand (negate = operand is signed and negative) and
// to restore the sign of a result (negate = result should be negative).
// Ports:
//   value   in  W  input word
//   negate  in  1  when high, result = -value; otherwise result = value
//   result  out W  value or its two's-complement negation (wraps naturally)
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? ({W{1'b0}} - value) : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle integer multiply/divide unit for the EX stage. Handles MULT,
// MULTU, DIV and DIVU with one 64-bit shift register shared by both
// algorithms and a fixed 33-cycle start-to-done latency.
// Ports:
//   clk        in  1   system clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   start      in  1   request a new operation (sampled only in IDLE)
//   op         in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      in  DW  multiplicand / dividend
//   src_b      in  DW  multiplier / divisor
//   cancel     in  1   flush: aborts an operation in progress
//   stall_req  out 1   holds the pipeline while an operation is pending
//   done       out 1   one-cycle pulse, hi_result/lo_result valid
//   hi_result  out DW  product[63:32] or remainder
//   lo_result  out DW  product[31:0] or quotient
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          cancel,
  output logic          stall_req,
  output logic          done,
  output logic [DW-1:0] hi_result,
  output logic [DW-1:0] lo_result
);

  md_state_e          state;
  md_state_e          state_next;
  md_op_e             op_in;
  md_op_e             op_q;
  logic               in_signed;
  logic               in_div;
  logic               accept;
  logic               last_iter;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [DW-1:0]      a_mag;
  logic [DW-1:0]      b_mag;
  logic [DW-1:0]      m_q;
  logic [2*DW-1:0]    acc;
  logic [2*DW-1:0]    acc_next;
  logic [DW:0]        sum;
  logic [DW:0]        trial;
  logic [CNT_W-1:0]   cnt;
  logic [2*DW-1:0]    prod_fixed;
  logic [DW-1:0]      quot_fixed;
  logic [DW-1:0]      rem_fixed;

  assign op_in     = md_op_e'(op);
  assign in_signed = is_signed_op(op_in);
  assign in_div    = is_div_op(op_in);
  assign accept    = (state == ST_IDLE) && start && !cancel;
  assign last_iter = (state == ST_CALC) && (cnt == CNT_W'(ITERATIONS - 1));

  assign stall_req = accept || (state == ST_CALC);
  // done is derived from the registered DONE state; a flush arriving in that
  // cycle still kills it so the HI/LO write is dropped.
  assign done      = (state == ST_DONE) && !cancel;

  // Operand preparation: magnitudes for signed ops, raw values otherwise.
  md_sign_fix #(.W(DW)) u_abs_a (
    .value  (src_a),
    .negate (in_signed && src_a[DW-1]),
    .result (a_mag)
  );

  md_sign_fix #(.W(DW)) u_abs_b (
    .value  (src_b),
    .negate (in_signed && src_b[DW-1]),
    .result (b_mag)
  );

  // Result correction works on acc_next so the final iteration and the sign
  // fix land in the same clock edge.
  md_sign_fix #(.W(2*DW)) u_fix_prod (
    .value  (acc_next),
    .negate (neg_res),
    .result (prod_fixed)
  );

  md_sign_fix #(.W(DW)) u_fix_quot (
    .value  (acc_next[DW-1:0]),
    .negate (neg_res),
    .result (quot_fixed)
  );

  md_sign_fix #(.W(DW)) u_fix_rem (
    .value  (acc_next[2*DW-1:DW]),
    .negate (neg_rem),
    .result (rem_fixed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_CALC;
      end
      ST_CALC: begin
        if (cancel)         state_next = ST_IDLE;
        else if (last_iter) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One iteration of the shared datapath.
  // Multiply: acc = {partial_hi, multiplier}; the low bit selects whether the
  // multiplicand is added to the upper half, then the whole word shifts right
  // with the carry entering at the top.
  // Divide (restoring): acc = {remainder, dividend/quotient}; the word shifts
  // left one bit and the divisor is subtracted from the 33-bit partial
  // remainder. No borrow means the subtraction sticks and a 1 enters the
  // quotient. The remainder is always below the divisor, so 33 bits of trial
  // width cannot overflow.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    trial    = '0;
    if (is_div_op(op_q)) begin
      trial = acc[2*DW-1:DW-1] - {1'b0, m_q};
      if (!trial[DW]) begin
        acc_next = {trial[DW-1:0], acc[DW-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*DW-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, m_q} : {(DW+1){1'b0}});
      acc_next = {sum, acc[DW-1:1]};
    end
  end

  // Operand latch, iteration register, counter and result registers.
  // m_q holds whichever operand is repeatedly added/subtracted: the
  // multiplicand for multiply, the divisor for divide. On divide by zero the
  // restoring loop leaves |src_a| as the remainder, and restoring the
  // dividend's sign gives back src_a, so only the quotient needs forcing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= MD_MULT;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      m_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      hi_result <= '0;
      lo_result <= '0;
    end else if (accept) begin
      op_q     <= op_in;
      neg_res  <= in_signed && (src_a[DW-1] ^ src_b[DW-1]);
      neg_rem  <= in_signed && in_div && src_a[DW-1];
      div_zero <= (src_b == '0);
      cnt      <= '0;
      if (in_div) begin
        m_q <= b_mag;
        acc <= {{DW{1'b0}}, a_mag};
      end else begin
        m_q <= a_mag;
        acc <= {{DW{1'b0}}, b_mag};
      end
    end else if ((state == ST_CALC) && !cancel) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        if (is_div_op(op_q)) begin
          hi_result <= rem_fixed;
          lo_result <= div_zero ? {DW{1'b1}} : quot_fixed;
        end else begin
          hi_result <= prod_fixed[2*DW-1:DW];
          lo_result <= prod_fixed[DW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Self-checking bench for mul_div_unit: directed corner cases followed by
// random operations, all compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stall_req;
  logic        done;
  logic [31:0] hi_result;
  logic [31:0] lo_result;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int accepted = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mul_div_unit #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .stall_req (stall_req),
    .done      (done),
    .hi_result (hi_result),
    .lo_result (lo_result)
  );

  always #5 clk = ~clk;

  // Counts every done pulse so the total can be matched against the number
  // of operations that should have completed.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Reference: plain 64-bit arithmetic. SystemVerilog division truncates
  // toward zero and the remainder follows the dividend, which is exactly the
  // required signed behaviour; truncating to 32 bits gives the overflow wrap.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation starting at the current negedge (unit in IDLE).
  // cancel_at > 0 flushes at that CALC cycle; junk_at > 0 pulses start with
  // random operands at that CALC cycle, which must be ignored.
  // Returns at cycle 34 (IDLE), so a following call is back-to-back.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int cancel_at,
                               input int junk_at);
    logic [63:0] exp;
    exp = refModel(o, a, b);
    op = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    #1;
    checkOutput("stall_cycle0", 64'(stall_req), 64'd1);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      start = (cyc == junk_at);
      if (cyc == junk_at) begin
        op = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
      end
      if (cancel_at > 0 && cyc == cancel_at) begin
        cancel = 1'b1;
        #1;
        checkOutput("stall_at_cancel", 64'(stall_req), 64'd1);
        @(negedge clk);
        cancel = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("stall_after_cancel", 64'(stall_req), 64'd0);
        checkOutput("done_after_cancel", 64'(done), 64'd0);
        repeat (30) @(negedge clk);
        #1;
        checkOutput("hi_kept_after_cancel", 64'(hi_result), 64'(last_hi));
        checkOutput("lo_kept_after_cancel", 64'(lo_result), 64'(last_lo));
        return;
      end
      #1;
      checkOutput("stall_calc", 64'(stall_req), 64'd1);
      checkOutput("done_early", 64'(done), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("done_cycle33", 64'(done), 64'd1);
    checkOutput("stall_cycle33", 64'(stall_req), 64'd0);
    checkOutput("hi_result", 64'(hi_result), 64'(exp[63:32]));
    checkOutput("lo_result", 64'(lo_result), 64'(exp[31:0]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    accepted++;
    @(negedge clk);
    #1;
    checkOutput("done_cycle34", 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    op = 2'b00;
    src_a = '0;
    src_b = '0;
    #1;
    checkOutput("reset_hi", 64'(hi_result), 64'd0);
    checkOutput("reset_lo", 64'(lo_result), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_stall", 64'(stall_req), 64'd0);
    start = 1'b1;
    #1;
    checkOutput("reset_stall_follows_start", 64'(stall_req), 64'd1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 5);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 17);
    applyStimulus(2'b11, 32'd7, 32'd2, 0, 0);
    applyStimulus(2'b11, 32'd5, 32'd0, 0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    // Flush mid-CALC, then the same operation is accepted and completes.
    applyStimulus(2'b11, 32'd100, 32'd3, 10, 0);
    applyStimulus(2'b11, 32'd100, 32'd3, 0, 0);

    // start together with cancel in IDLE must not be accepted.
    op = 2'b01;
    src_a = 32'd9;
    src_b = 32'd9;
    start = 1'b1;
    cancel = 1'b1;
    #1;
    checkOutput("start_cancel_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b0;
    #1;
    checkOutput("start_cancel_not_accepted", 64'(stall_req), 64'd0);

    // Random operations with occasional zero divisors and ignored starts.
    for (int n = 0; n < 16; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
      applyStimulus(ro, ra, rb, 0, int'($urandom_range(0, 31)));
    end

    // Asynchronous reset in the middle of CALC, off the clock edges.
    op = 2'b01;
    src_a = $urandom;
    src_b = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_stall", 64'(stall_req), 64'd0);
    checkOutput("async_rst_done", 64'(done), 64'd0);
    checkOutput("async_rst_hi", 64'(hi_result), 64'd0);
    checkOutput("async_rst_lo", 64'(lo_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    #1;
    checkOutput("after_rst_idle", 64'(stall_req), 64'd0);
    @(negedge clk);

    applyStimulus(2'b10, 32'd100, 32'hFFFF_FFFD, 0, 0);

    @(negedge clk);
    checkOutput("done_count", 64'(done_seen), 64'(accepted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit in the EX stage. Executes MULT, MULTU, DIV and DIVU with a shared 32-iteration shift datapath and produces the 64-bit result pair that travels down the pipeline to the HI/LO register file, where `done` qualifies the HI/LO write enables. It raises a stall request so the pipeline freezes until the result is ready, and aborts cleanly on flush.

## Interface
- `DW`, 32, operand width; only 32 is supported.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs operand (multiplicand / dividend).
- `src_b`  in  32  rt operand (multiplier / divisor).
- `cancel`  in  1  flush; aborts any operation in progress.
- `stall_req`  out  1  combinational: `(IDLE & start & ~cancel) | CALC`.
- `done`  out  1  registered one-cycle pulse; results valid.
- `hi_result`  out  32  product[63:32] or remainder.
- `lo_result`  out  32  product[31:0] or quotient.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `start & ~cancel`, latch `op`. For signed ops, latch |src_a| and |src_b| plus sign flags; for unsigned ops, latch the raw operands. Clear the 6-bit iteration counter, then go to CALC.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step on the {remainder, quotient} 64-bit register.
  - After iteration 32, apply sign correction, register `hi_result`/`lo_result`, and go to DONE.
- DONE: `done=1` for exactly one cycle, then return to IDLE. A `start` in DONE is ignored.
- Sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Divide by zero (DIV and DIVU): `lo_result=32'hFFFFFFFF`, `hi_result=src_a`. Latency is unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives `lo_result=0x80000000`, `hi_result=0` (natural 32-bit wrap).
- `start` while in CALC or DONE is ignored; the upstream stage is held by `stall_req`.
- `cancel`:
  - In CALC, returns to IDLE on the next edge; no `done`; `hi_result`/`lo_result` keep their previous values.
  - In DONE, suppresses `done`.
  - `start & cancel` in IDLE: `cancel` wins and the operation is not accepted.
- `hi_result`/`lo_result` hold their value until the next completed operation.

## Timing
- Cycle 0: IDLE with `start` (accepted); `stall_req=1`.
- Cycles 1–32: CALC; `stall_req=1`.
- Cycle 33: DONE; `done=1`, results valid, `stall_req=0`.
- Start-to-done latency is 33 cycles. This is fixed for all ops and operand values; there is no early termination.
- Back-to-back operations: the next `start` can be accepted at cycle 34 (IDLE).
- Reset: state goes to IDLE immediately. `done=0`, `hi_result=0`, `lo_result=0`, counter=0. `stall_req` follows from the state, so it is 0 unless `start` is high.
- Reset asserted mid-CALC abandons the operation with no `done`.

## Structure
- Put the `op` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`), the state encodings and the iteration count 32 in `lib/defines.vh`.
- One sub-module is natural: `md_sign_fix`, a combinational helper for absolute value and conditional negate. It is instantiated for operand preparation and for result correction (64-bit product, 32-bit quotient and remainder).
- The iteration datapath stays in `mul_div_unit`. A single 64-bit working register is shared by multiply and divide.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi=0xFFFFFFFE`, `lo=0x00000001`; `done` exactly 33 cycles after `start`; `stall_req` high for cycles 0–32.
- MULT 0xFFFFFFFD (−3) × 7 → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`. MULT 0x80000000 × 0x80000000 → `hi=0x40000000`, `lo=0`.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU 7 / 2 → `lo=3`, `hi=1`.
- DIVU 5 / 0 → `lo=0xFFFFFFFF`, `hi=5`. DIV 0x80000000 / 0xFFFFFFFF → `lo=0x80000000`, `hi=0`.
- DIVU 100 / 3 with `cancel` at cycle 10 → no `done`, `stall_req=0` the next cycle, results unchanged. A new `start` (DIVU 100 / 3) is then accepted and gives `lo=33`, `hi=1` at +33.
- Asynchronous `rst` pulse mid-CALC (not clock-aligned) → immediately IDLE and outputs 0. `start` pulses during CALC are ignored, with exactly one `done` per accepted op.
